// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the MEM stage and a variable-latency data port.
// Checks alignment, builds byte enables and lane data, handshakes with memory and extends loads.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        bus_err,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        m_req,
  output logic        m_we,
  output logic [3:0]  m_be,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata
);

  // state | meaning
  // IDLE  | waiting for a MEM-stage access; misaligned ones raise an exception here
  // BUSY  | request held on the memory port until ack or timeout
  // DONE  | one-cycle completion, rvalid high, pipeline released
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [2:0] OP_W  = 3'b000;
  localparam logic [2:0] OP_HU = 3'b001;
  localparam logic [2:0] OP_HS = 3'b010;
  localparam logic [2:0] OP_BU = 3'b011;
  localparam logic [2:0] OP_BS = 3'b100;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        m_req_q, m_req_d;
  logic        m_we_q, m_we_d;
  logic [3:0]  m_be_q, m_be_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        bus_err_q, bus_err_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  off_q, off_d;

  logic        misaligned;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [15:0] ld_half;
  logic [7:0]  ld_byte;
  logic [31:0] ld_ext;
  logic        timeout_hit;

  always_comb begin
    misaligned = 1'b0;
    st_be      = 4'b1111;
    st_wdata   = wdata;
    unique case (mem_op)
      OP_W: begin
        misaligned = (addr[1:0] != 2'b00);
      end
      OP_HU, OP_HS: begin
        misaligned = addr[0];
        st_be      = addr[1] ? 4'b1100 : 4'b0011;
        st_wdata   = {wdata[15:0], wdata[15:0]};
      end
      OP_BU, OP_BS: begin
        st_be    = 4'b0001 << addr[1:0];
        st_wdata = {4{wdata[7:0]}};
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
  end

  // Lane selection uses the offset latched at accept, not the live address.
  always_comb begin
    ld_half = off_q[1] ? m_rdata[31:16] : m_rdata[15:0];
    ld_byte = m_rdata[7:0];
    unique case (off_q)
      2'd0: ld_byte = m_rdata[7:0];
      2'd1: ld_byte = m_rdata[15:8];
      2'd2: ld_byte = m_rdata[23:16];
      2'd3: ld_byte = m_rdata[31:24];
      default: ld_byte = m_rdata[7:0];
    endcase
    unique case (op_q)
      OP_HU:   ld_ext = {16'h0000, ld_half};
      OP_HS:   ld_ext = {{16{ld_half[15]}}, ld_half};
      OP_BU:   ld_ext = {24'h000000, ld_byte};
      OP_BS:   ld_ext = {{24{ld_byte[7]}}, ld_byte};
      default: ld_ext = m_rdata;
    endcase
  end

  assign timeout_hit = (TIMEOUT != 0) && ((cnt_q + 32'd1) == TIMEOUT);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_be_d    = m_be_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    bus_err_d = 1'b0;
    op_d      = op_q;
    off_d     = off_q;
    stall     = 1'b0;
    exc_adel  = 1'b0;
    exc_ades  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (mem_req) begin
          if (misaligned) begin
            exc_adel = ~mem_we;
            exc_ades = mem_we;
          end else begin
            stall     = 1'b1;
            state_d   = ST_BUSY;
            cnt_d     = 32'd0;
            m_req_d   = 1'b1;
            m_we_d    = mem_we;
            m_addr_d  = {addr[31:2], 2'b00};
            m_be_d    = mem_we ? st_be : 4'b1111;
            m_wdata_d = mem_we ? st_wdata : 32'd0;
            op_d      = mem_op;
            off_d     = addr[1:0];
          end
        end
      end

      ST_BUSY: begin
        stall = 1'b1;
        cnt_d = cnt_q + 32'd1;
        if (m_ack) begin
          rdata_d  = m_we_q ? 32'd0 : ld_ext;
          rvalid_d = 1'b1;
          m_req_d  = 1'b0;
          state_d  = ST_DONE;
        end else if (timeout_hit) begin
          rdata_d   = 32'd0;
          rvalid_d  = 1'b1;
          bus_err_d = 1'b1;
          m_req_d   = 1'b0;
          state_d   = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        m_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 32'd0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_be_q    <= 4'b0000;
      m_addr_q  <= 32'd0;
      m_wdata_q <= 32'd0;
      rdata_q   <= 32'd0;
      rvalid_q  <= 1'b0;
      bus_err_q <= 1'b0;
      op_q      <= 3'b000;
      off_q     <= 2'b00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_be_q    <= m_be_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      bus_err_q <= bus_err_d;
      op_q      <= op_d;
      off_q     <= off_d;
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_be    = m_be_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign rdata   = rdata_q;
  assign rvalid  = rvalid_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with TIMEOUT=4: loads, stores, exceptions,
// timeout, reset mid-access and back-to-back requests.
module tb_mem_access_ctrl;

  logic        clk;
  logic        reset;
  logic        mem_req;
  logic        mem_we;
  logic [2:0]  mem_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rvalid;
  logic        bus_err;
  logic        exc_adel;
  logic        exc_ades;
  logic        m_req;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ack;
  logic [31:0] m_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_ctrl #(.TIMEOUT(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_op   (mem_op),
    .addr     (addr),
    .wdata    (wdata),
    .stall    (stall),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .bus_err  (bus_err),
    .exc_adel (exc_adel),
    .exc_ades (exc_ades),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_be     (m_be),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_ack    (m_ack),
    .m_rdata  (m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Full access; exp_lat is the cycle (accept = 0) in which rvalid must appear.
  task automatic access(input string tag, input logic we, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] wd, input int ack_wait,
                        input logic [31:0] mrd, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd, input logic [31:0] exp_rd,
                        input logic exp_err, input int exp_lat);
    int busy;
    int lat;
    bit done;
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = we; mem_op = op; addr = a; wdata = wd;
    m_ack = 1'b0; m_rdata = mrd;
    #1;
    chk({tag, ".stall_c0"}, 32'(stall), 32'd1);
    chk({tag, ".exc_c0"}, 32'({exc_adel, exc_ades}), 32'd0);
    chk({tag, ".rvalid_c0"}, 32'(rvalid), 32'd0);
    busy = 0; lat = 0; done = 1'b0;
    for (int c = 1; c <= 20 && !done; c++) begin
      @(posedge clk); #1;
      if (rvalid) begin
        done = 1'b1;
        lat  = c;
      end else begin
        if (c == 1) begin
          chk({tag, ".m_addr"}, m_addr, {a[31:2], 2'b00});
          chk({tag, ".m_be"}, 32'(m_be), 32'(exp_be));
          chk({tag, ".m_we"}, 32'(m_we), 32'(we));
          if (we) chk({tag, ".m_wdata"}, m_wdata, exp_wd);
        end
        if (m_req && stall) busy++;
        m_ack = (ack_wait >= 0) && (c - 1 == ack_wait);
      end
    end
    m_ack = 1'b0;
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".busy_cycles"}, 32'(busy), 32'(exp_lat - 1));
    chk({tag, ".rdata"}, rdata, exp_rd);
    chk({tag, ".bus_err"}, 32'(bus_err), 32'(exp_err));
    chk({tag, ".stall_done"}, 32'(stall), 32'd0);
    chk({tag, ".m_req_done"}, 32'(m_req), 32'd0);
  endtask

  task automatic exc_case(input string tag, input logic we, input logic [2:0] op,
                          input logic [31:0] a, input logic exp_adel, input logic exp_ades);
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = we; mem_op = op; addr = a; wdata = 32'h1234_5678;
    #1;
    chk({tag, ".adel"}, 32'(exc_adel), 32'(exp_adel));
    chk({tag, ".ades"}, 32'(exc_ades), 32'(exp_ades));
    chk({tag, ".stall"}, 32'(stall), 32'd0);
    @(posedge clk); #1;
    chk({tag, ".m_req"}, 32'(m_req), 32'd0);
    chk({tag, ".rvalid"}, 32'(rvalid), 32'd0);
    mem_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mem_req = 1'b0; mem_we = 1'b0; mem_op = 3'b000;
    addr = 32'd0; wdata = 32'd0; m_ack = 1'b0; m_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst.m_req", 32'(m_req), 32'd0);
    chk("rst.m_be", 32'(m_be), 32'd0);
    chk("rst.m_addr", m_addr, 32'd0);
    chk("rst.rdata", rdata, 32'd0);
    chk("rst.rvalid", 32'(rvalid), 32'd0);
    chk("rst.stall", 32'(stall), 32'd0);

    // tag          we    op      addr          wdata         wait mrdata        be       wdata_exp     rdata_exp     err  lat
    access("lb",   1'b0, 3'b100, 32'h0000_1003, 32'd0,         0, 32'h80FF_0000, 4'b1111, 32'd0,        32'hFFFF_FF80, 1'b0, 2);
    access("lhu",  1'b0, 3'b001, 32'h0000_2002, 32'd0,         3, 32'h9ABC_1234, 4'b1111, 32'd0,        32'h0000_9ABC, 1'b0, 5);
    access("lh",   1'b0, 3'b010, 32'h0000_2002, 32'd0,         3, 32'h9ABC_1234, 4'b1111, 32'd0,        32'hFFFF_9ABC, 1'b0, 5);
    access("sb",   1'b1, 3'b011, 32'h0000_0011, 32'h0000_00A5, 1, 32'hFFFF_FFFF, 4'b0010, 32'hA5A5_A5A5, 32'd0,        1'b0, 3);
    access("sh",   1'b1, 3'b001, 32'h0000_0012, 32'hCAFE_5678, 0, 32'hFFFF_FFFF, 4'b1100, 32'h5678_5678, 32'd0,        1'b0, 2);
    access("sw",   1'b1, 3'b000, 32'h0000_0020, 32'hDEAD_BEEF, 2, 32'd0,         4'b1111, 32'hDEAD_BEEF, 32'd0,        1'b0, 4);
    access("lbu",  1'b0, 3'b011, 32'h0000_0005, 32'd0,         0, 32'h1122_3344, 4'b1111, 32'd0,        32'h0000_0033, 1'b0, 2);
    access("lw",   1'b0, 3'b000, 32'h0000_0008, 32'd0,         1, 32'h8765_4321, 4'b1111, 32'd0,        32'h8765_4321, 1'b0, 3);
    access("tmo",  1'b0, 3'b000, 32'h0000_0040, 32'd0,        -1, 32'hFFFF_FFFF, 4'b1111, 32'd0,        32'd0,        1'b1, 5);
    access("lh_lo",1'b0, 3'b010, 32'h0000_3000, 32'd0,         0, 32'h0000_8001, 4'b1111, 32'd0,        32'hFFFF_8001, 1'b0, 2);
    mem_req = 1'b0;

    exc_case("lw_mis",  1'b0, 3'b000, 32'h0000_0006, 1'b1, 1'b0);
    exc_case("sh_mis",  1'b1, 3'b001, 32'h0000_0003, 1'b0, 1'b1);
    exc_case("rsv_ld",  1'b0, 3'b101, 32'h0000_0000, 1'b1, 1'b0);
    exc_case("rsv_st",  1'b1, 3'b111, 32'h0000_0004, 1'b0, 1'b1);

    // Reset in the second BUSY cycle abandons the access.
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b0; mem_op = 3'b000; addr = 32'h0000_0080; m_ack = 1'b0;
    @(posedge clk); #1;
    chk("rstb.m_req_busy", 32'(m_req), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; mem_req = 1'b0;
    #1;
    chk("rstb.m_req", 32'(m_req), 32'd0);
    chk("rstb.m_addr", m_addr, 32'd0);
    chk("rstb.m_be", 32'(m_be), 32'd0);
    chk("rstb.rdata", rdata, 32'd0);
    chk("rstb.rvalid", 32'(rvalid), 32'd0);
    chk("rstb.stall", 32'(stall), 32'd0);
    m_ack = 1'b1;
    @(posedge clk); #1;
    m_ack = 1'b0;
    chk("stray.rvalid", 32'(rvalid), 32'd0);
    chk("stray.m_req", 32'(m_req), 32'd0);
    @(posedge clk); #1;
    chk("stray.rvalid2", 32'(rvalid), 32'd0);

    access("post", 1'b0, 3'b100, 32'h0000_0101, 32'd0, 1, 32'h0000_7F00, 4'b1111, 32'd0, 32'h0000_007F, 1'b0, 3);
    mem_req = 1'b0;
    @(posedge clk); #1;
    chk("idle.rvalid", 32'(rvalid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Load/store sequencer between the pipeline MEM stage and a variable-latency data memory/bridge port. It checks alignment, generates byte enables and lane-replicated store data, and holds a req/ack handshake with memory while stalling the pipeline. It also sign/zero-extends returned load data and reports a bus timeout. It replaces direct combinational DM access in the MEM stage.

## Interface
- `TIMEOUT`, default 255: max BUSY cycles without `m_ack` before bus error; 0 disables timeout.
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `mem_req` in 1: MEM stage has a load/store; held stable while `stall`=1.
- `mem_we` in 1: 1 = store, 0 = load.
- `mem_op` in 3: 000 word, 001 half unsigned, 010 half signed, 011 byte unsigned, 100 byte signed; 101–111 reserved.
- `addr` in 32: byte address.
- `wdata` in 32: store data, value in low bits.
- `stall` out 1: freeze pipeline.
- `rdata` out 32: extended load data, valid when `rvalid`.
- `rvalid` out 1: access complete (load or store), one cycle.
- `bus_err` out 1: access completed by timeout; qualifies `rvalid`.
- `exc_adel` / `exc_ades` out 1: load/store address-error exception, combinational.
- `m_req` out 1, `m_we` out 1, `m_be` out 4, `m_addr` out 32 (bits[1:0]=00), `m_wdata` out 32: memory request, all registered.
- `m_ack` in 1: memory completes request this cycle; `m_rdata` in 32 valid with it.

## Operation
- States: IDLE, BUSY, DONE.
- Misaligned: half with `addr[0]`=1; word with `addr[1:0]`≠0; any reserved `mem_op`.
- IDLE with `mem_req`=1, misaligned: `exc_adel` (load) or `exc_ades` (store) high that cycle, `stall`=0, no memory access, stay IDLE.
- IDLE with `mem_req`=1, aligned: latch request, go BUSY.
  - `m_addr`={addr[31:2],2'b00}; `m_we`=`mem_we`.
  - Loads: `m_be`=1111.
  - Stores, word: `m_be`=1111, `m_wdata`=`wdata`.
  - Stores, half: `m_be`= `addr[1]` ? 1100 : 0011, `m_wdata`={wdata[15:0],wdata[15:0]}.
  - Stores, byte: `m_be`=0001<<`addr[1:0]`, `m_wdata`={4{wdata[7:0]}}.
- BUSY: `m_req`=1. Timeout counter increments each cycle.
  - `m_ack` sampled 1: capture extended `m_rdata` into `rdata` (loads; stores give 0), go DONE.
  - Else if counter reaches `TIMEOUT`: `rdata`=0, `bus_err`=1, go DONE.
  - `m_ack` wins when it coincides with timeout.
- DONE: `rvalid`=1, `stall`=0, `m_req`=0. Go IDLE. `mem_req` is ignored this cycle.
- Load extension uses offset `addr[1:0]` latched at accept:
  - Half selects `m_rdata[31:16]` if offset[1], else `[15:0]`.
  - Byte selects lane `offset`.
  - Signed ops replicate the selected MSB into the upper bits; unsigned ops zero-fill.
- `stall` = (IDLE & `mem_req` & aligned) | BUSY.
- `m_ack` in IDLE/DONE is ignored.

## Timing
- Reset: state IDLE, counter 0. `m_req`, `m_we`, `m_be`, `m_addr`, `m_wdata`, `rdata`, `rvalid`, `bus_err` all 0.
- Reset mid-BUSY: `m_req` drops at the next edge and the access is abandoned without `rvalid`.
- Zero-wait memory (ack in first BUSY cycle): accept at cycle 0, BUSY at cycle 1, DONE at cycle 2.
  - `stall` high cycles 0–1; `rvalid` cycle 2.
  - Minimum access is 3 cycles; each ack delay cycle adds 1.
- Timeout: with no ack, DONE comes after exactly `TIMEOUT` BUSY cycles.
- Back-to-back: the next request is accepted in the IDLE cycle right after DONE.
- Exceptions are same-cycle combinational and never assert `stall`.

## Test plan
- lb, addr=0x1003, ack delay 0 → `m_addr`=0x1000, `m_be`=1111. With `m_rdata`=0x80FF_0000 → `rdata`=0xFFFF_FF80, `rvalid` at cycle 2, `stall` high cycles 0–1.
- lhu, addr=0x2002, `m_rdata`=0x9ABC_1234, ack after 3 waits → `rdata`=0x0000_9ABC. lh with the same stimulus → 0xFFFF_9ABC.
- sb, addr=0x11, wdata=0x0000_00A5 → `m_be`=0010, `m_wdata`=0xA5A5_A5A5. sh, addr=0x12 → `m_be`=1100.
- lw, addr=0x6 → `exc_adel`=1 same cycle, `stall`=0, `m_req` never asserts. sh, addr=0x3 → `exc_ades`=1. Reserved op 101 → exception.
- `TIMEOUT`=4, no ack → `m_req` high 4 cycles, then `rvalid`=`bus_err`=1, `rdata`=0. Ack on the 4th cycle → normal completion with `bus_err`=0.
- `reset` asserted in second BUSY cycle → next cycle all outputs 0, state IDLE. A later request completes normally; a stray `m_ack` in IDLE has no effect.
